// File: rtl/pipe_ctrl_if.sv
// Control interface between the pipeline sequencer and the core datapath.
// Carries the decode/execute hazard inputs, the data-memory handshake and the
// per-stage enable/flush/redirect controls.
interface pipe_ctrl_if;
  logic [4:0]  id_rs1_ind;
  logic [4:0]  id_rs2_ind;
  logic        id_rs1_used;
  logic        id_rs2_used;
  logic [4:0]  ex_rd_ind;
  logic        ex_mem_read;
  logic        ex_jmp_take;
  logic [31:0] ex_jmp_addr;
  logic        mem_req;
  logic        mem_ready;

  logic        pc_en;
  logic        pc_sel;
  logic [31:0] pc_redirect;
  logic        if_id_en;
  logic        if_id_flush;
  logic        id_ex_en;
  logic        id_ex_flush;
  logic        ex_mem_en;
  logic        mem_timeout;

  // datapath side: supplies hazard/memory status, consumes stage controls
  modport master (
    output id_rs1_ind, id_rs2_ind, id_rs1_used, id_rs2_used, ex_rd_ind,
           ex_mem_read, ex_jmp_take, ex_jmp_addr, mem_req, mem_ready,
    input  pc_en, pc_sel, pc_redirect, if_id_en, if_id_flush, id_ex_en,
           id_ex_flush, ex_mem_en, mem_timeout
  );

  // sequencer side
  modport slave (
    input  id_rs1_ind, id_rs2_ind, id_rs1_used, id_rs2_used, ex_rd_ind,
           ex_mem_read, ex_jmp_take, ex_jmp_addr, mem_req, mem_ready,
    output pc_en, pc_sel, pc_redirect, if_id_en, if_id_flush, id_ex_en,
           id_ex_flush, ex_mem_en, mem_timeout
  );
endinterface

// File: rtl/pipe_ctrl.sv
// Pipeline sequencer for the 5-stage core: load-use bubbles, taken-jump
// redirects with IF/ID flush hold-off, and data-memory freeze with timeout.
//
//   state       | meaning
//   ------------+-----------------------------------------------------------
//   ST_INIT     | post-reset: all stages held and flushed for one cycle
//   ST_RUN      | normal flow; stall, redirect and load-use decoded here
//   ST_MEM_WAIT | data memory busy: whole pipe frozen, timeout timer running
//   ST_REDIRECT | IF/ID flush held while IMEM returns the redirected fetch
//
// Priority inside ST_RUN is mem stall > redirect > load-use. Both timers are
// down-counters; the wait timer is loaded with MEM_TIMEOUT-1 because the
// stalling RUN cycle already counts as the first wait cycle.
module pipe_ctrl #(
  parameter int unsigned REDIR_CYC   = 1,
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  pipe_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_INIT     = 2'd0,
    ST_RUN      = 2'd1,
    ST_MEM_WAIT = 2'd2,
    ST_REDIRECT = 2'd3
  } state_t;

  localparam logic [7:0] WAIT_LOAD  = 8'(MEM_TIMEOUT - 1);
  localparam logic [2:0] REDIR_LOAD = 3'(REDIR_CYC);

  state_t     state, state_nxt;
  logic [7:0] wait_cnt, wait_cnt_nxt;
  logic [2:0] redir_cnt, redir_cnt_nxt;
  logic       timeout_q, timeout_nxt;

  logic mem_stall;
  logic load_use;

  assign mem_stall = bus.mem_req & ~bus.mem_ready;
  assign load_use  = bus.ex_mem_read & (bus.ex_rd_ind != 5'd0) &
                     ((bus.id_rs1_used & (bus.id_rs1_ind == bus.ex_rd_ind)) |
                      (bus.id_rs2_used & (bus.id_rs2_ind == bus.ex_rd_ind)));

  // state, timers and sticky timeout flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_INIT;
      wait_cnt  <= 8'd0;
      redir_cnt <= 3'd0;
      timeout_q <= 1'b0;
    end else begin
      state     <= state_nxt;
      wait_cnt  <= wait_cnt_nxt;
      redir_cnt <= redir_cnt_nxt;
      timeout_q <= timeout_nxt;
    end
  end

  // next-state and timer update
  always_comb begin
    state_nxt     = state;
    wait_cnt_nxt  = wait_cnt;
    redir_cnt_nxt = redir_cnt;
    timeout_nxt   = timeout_q;
    case (state)
      ST_INIT: state_nxt = ST_RUN;
      ST_RUN: begin
        if (mem_stall) begin
          state_nxt    = ST_MEM_WAIT;
          wait_cnt_nxt = WAIT_LOAD;
        end else if (bus.ex_jmp_take && (REDIR_CYC != 0)) begin
          state_nxt     = ST_REDIRECT;
          redir_cnt_nxt = REDIR_LOAD;
        end
      end
      ST_MEM_WAIT: begin
        if (bus.mem_ready) begin
          state_nxt = ST_RUN;
        end else if (wait_cnt <= 8'd1) begin
          timeout_nxt  = 1'b1;
          wait_cnt_nxt = 8'd0;
          state_nxt    = ST_RUN;
        end else begin
          wait_cnt_nxt = wait_cnt - 8'd1;
        end
      end
      ST_REDIRECT: begin
        if (redir_cnt <= 3'd1) begin
          redir_cnt_nxt = 3'd0;
          state_nxt     = ST_RUN;
        end else begin
          redir_cnt_nxt = redir_cnt - 3'd1;
        end
      end
      default: state_nxt = ST_INIT;
    endcase
  end

  // stage enables, flushes and PC redirect decoded from state and inputs
  always_comb begin
    bus.pc_en       = 1'b0;
    bus.pc_sel      = 1'b0;
    bus.pc_redirect = 32'd0;
    bus.if_id_en    = 1'b0;
    bus.if_id_flush = 1'b0;
    bus.id_ex_en    = 1'b0;
    bus.id_ex_flush = 1'b0;
    bus.ex_mem_en   = 1'b0;
    case (state)
      ST_INIT: begin
        bus.if_id_flush = 1'b1;
        bus.id_ex_flush = 1'b1;
      end
      ST_RUN: begin
        if (mem_stall) begin
          bus.pc_en = 1'b0;
        end else if (bus.ex_jmp_take) begin
          bus.pc_en       = 1'b1;
          bus.pc_sel      = 1'b1;
          bus.pc_redirect = bus.ex_jmp_addr;
          bus.if_id_en    = 1'b1;
          bus.if_id_flush = 1'b1;
          bus.id_ex_en    = 1'b1;
          bus.id_ex_flush = 1'b1;
          bus.ex_mem_en   = 1'b1;
        end else if (load_use) begin
          bus.id_ex_en    = 1'b1;
          bus.id_ex_flush = 1'b1;
          bus.ex_mem_en   = 1'b1;
        end else begin
          bus.pc_en     = 1'b1;
          bus.if_id_en  = 1'b1;
          bus.id_ex_en  = 1'b1;
          bus.ex_mem_en = 1'b1;
        end
      end
      ST_REDIRECT: begin
        bus.pc_en       = 1'b1;
        bus.if_id_en    = 1'b1;
        bus.if_id_flush = 1'b1;
        bus.id_ex_en    = 1'b1;
        bus.ex_mem_en   = 1'b1;
      end
      default: bus.pc_en = 1'b0;
    endcase
  end

  assign bus.mem_timeout = timeout_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: each cycle the stimulus and a behavioural model's
// expected outputs are pushed to a scoreboard, then popped and compared
// against the DUT shortly after the inputs settle.
module tb_pipe_ctrl;

  localparam int P_REDIR = 1;
  localparam int P_TO    = 15;

  localparam int M_INIT = 0;
  localparam int M_RUN  = 1;
  localparam int M_WAIT = 2;
  localparam int M_RED  = 3;

  typedef struct packed {
    logic        rst_n;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        u1;
    logic        u2;
    logic [4:0]  rd;
    logic        mrd;
    logic        jt;
    logic [31:0] ja;
    logic        mq;
    logic        mrdy;
  } stim_t;

  typedef struct packed {
    logic        pc_en;
    logic        pc_sel;
    logic [31:0] pc_redirect;
    logic        if_id_en;
    logic        if_id_flush;
    logic        id_ex_en;
    logic        id_ex_flush;
    logic        ex_mem_en;
    logic        mem_timeout;
  } exp_t;

  logic clk;
  logic rst_n;
  pipe_ctrl_if bus();

  pipe_ctrl #(.REDIR_CYC(P_REDIR), .MEM_TIMEOUT(P_TO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int    n_checks = 0;
  int    n_errors = 0;
  string phase = "init";
  stim_t st;
  exp_t  sb_q[$];

  int m_state = M_INIT;
  int m_up    = 0;
  int m_rcnt  = 0;
  bit m_to    = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s/%s: got %h expected %h at %0t", phase, tag, obs, exp, $time);
    end
  endtask

  function automatic stim_t nop();
    stim_t s;
    s = '0;
    s.rst_n = 1'b1;
    return s;
  endfunction

  // model: expected outputs for this cycle, then advance model state
  task automatic predict(output exp_t e);
    bit stall, lu;
    e = '0;
    if (!st.rst_n) begin
      m_state = M_INIT;
      m_up    = 0;
      m_rcnt  = 0;
      m_to    = 1'b0;
    end
    stall = st.mq && !st.mrdy;
    lu = st.mrd && (st.rd != 0) &&
         ((st.u1 && (st.rs1 == st.rd)) || (st.u2 && (st.rs2 == st.rd)));
    e.mem_timeout = m_to;
    case (m_state)
      M_INIT: begin
        e.if_id_flush = 1'b1;
        e.id_ex_flush = 1'b1;
        if (st.rst_n) m_state = M_RUN;
      end
      M_RUN: begin
        if (stall) begin
          m_state = M_WAIT;
          m_up    = 1;
        end else if (st.jt) begin
          e.pc_en = 1; e.pc_sel = 1; e.pc_redirect = st.ja;
          e.if_id_en = 1; e.id_ex_en = 1; e.ex_mem_en = 1;
          e.if_id_flush = 1; e.id_ex_flush = 1;
          if (P_REDIR != 0) begin
            m_state = M_RED;
            m_rcnt  = P_REDIR;
          end
        end else if (lu) begin
          e.id_ex_en = 1; e.id_ex_flush = 1; e.ex_mem_en = 1;
        end else begin
          e.pc_en = 1; e.if_id_en = 1; e.id_ex_en = 1; e.ex_mem_en = 1;
        end
      end
      M_WAIT: begin
        if (st.mrdy) begin
          m_state = M_RUN;
        end else begin
          m_up++;
          if (m_up == P_TO) begin
            m_to    = 1'b1;
            m_state = M_RUN;
          end
        end
      end
      default: begin
        e.pc_en = 1; e.if_id_en = 1; e.id_ex_en = 1; e.ex_mem_en = 1;
        e.if_id_flush = 1;
        m_rcnt--;
        if (m_rcnt == 0) m_state = M_RUN;
      end
    endcase
  endtask

  // one clock cycle: drive, push expectation, sample and compare
  task automatic tick();
    exp_t e;
    exp_t g;
    @(negedge clk);
    rst_n               = st.rst_n;
    bus.id_rs1_ind      = st.rs1;
    bus.id_rs2_ind      = st.rs2;
    bus.id_rs1_used     = st.u1;
    bus.id_rs2_used     = st.u2;
    bus.ex_rd_ind       = st.rd;
    bus.ex_mem_read     = st.mrd;
    bus.ex_jmp_take     = st.jt;
    bus.ex_jmp_addr     = st.ja;
    bus.mem_req         = st.mq;
    bus.mem_ready       = st.mrdy;
    predict(e);
    sb_q.push_back(e);
    #1;
    g = sb_q.pop_front();
    chk("pc_en",       {31'd0, bus.pc_en},       {31'd0, g.pc_en});
    chk("pc_sel",      {31'd0, bus.pc_sel},      {31'd0, g.pc_sel});
    chk("pc_redirect", bus.pc_redirect,          g.pc_redirect);
    chk("if_id_en",    {31'd0, bus.if_id_en},    {31'd0, g.if_id_en});
    chk("if_id_flush", {31'd0, bus.if_id_flush}, {31'd0, g.if_id_flush});
    chk("id_ex_en",    {31'd0, bus.id_ex_en},    {31'd0, g.id_ex_en});
    chk("id_ex_flush", {31'd0, bus.id_ex_flush}, {31'd0, g.id_ex_flush});
    chk("ex_mem_en",   {31'd0, bus.ex_mem_en},   {31'd0, g.ex_mem_en});
    chk("mem_timeout", {31'd0, bus.mem_timeout}, {31'd0, g.mem_timeout});
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    st = nop();
    st.rst_n = 1'b0;
    rst_n = 1'b0;
    bus.id_rs1_ind = '0; bus.id_rs2_ind = '0; bus.id_rs1_used = 0; bus.id_rs2_used = 0;
    bus.ex_rd_ind = '0; bus.ex_mem_read = 0; bus.ex_jmp_take = 0; bus.ex_jmp_addr = '0;
    bus.mem_req = 0; bus.mem_ready = 0;

    phase = "reset";
    repeat (2) tick();
    st = nop();
    repeat (3) tick();

    phase = "loaduse_rs2";
    st = nop(); st.mrd = 1; st.rd = 5; st.rs2 = 5; st.u2 = 1;
    tick();
    st = nop(); st.rs2 = 5; st.u2 = 1;
    tick();
    phase = "loaduse_x0";
    st = nop(); st.mrd = 1; st.rd = 0; st.rs2 = 0; st.u2 = 1; st.rs1 = 0; st.u1 = 1;
    tick();
    phase = "loaduse_rs1";
    st = nop(); st.mrd = 1; st.rd = 7; st.rs1 = 7; st.u1 = 1;
    tick();
    phase = "loaduse_unused";
    st = nop(); st.mrd = 1; st.rd = 7; st.rs1 = 7; st.rs2 = 7;
    tick();
    phase = "loaduse_noload";
    st = nop(); st.rd = 7; st.rs1 = 7; st.u1 = 1;
    tick();

    phase = "redirect";
    st = nop(); st.jt = 1; st.ja = 32'h0000_0100;
    tick();
    st = nop();
    repeat (3) tick();

    phase = "memstall_jmp";
    st = nop(); st.mq = 1; st.jt = 1; st.ja = 32'h0000_0200;
    repeat (3) tick();
    st.mrdy = 1;
    tick();
    st = nop(); st.jt = 1; st.ja = 32'h0000_0200;
    tick();
    st = nop();
    repeat (2) tick();

    phase = "loaduse_and_jmp";
    st = nop(); st.mrd = 1; st.rd = 3; st.rs1 = 3; st.u1 = 1; st.jt = 1; st.ja = 32'hdead_beef;
    tick();
    st = nop();
    repeat (2) tick();

    phase = "timeout";
    st = nop(); st.mq = 1;
    repeat (P_TO + 1) tick();
    st = nop();
    repeat (4) tick();

    phase = "reset_in_redirect";
    st = nop(); st.jt = 1; st.ja = 32'h0000_0400;
    tick();
    st = nop(); st.rst_n = 0;
    tick();
    st = nop();
    repeat (2) tick();

    phase = "reset_in_wait";
    st = nop(); st.mq = 1;
    repeat (3) tick();
    st.rst_n = 0;
    tick();
    st = nop();
    repeat (3) tick();

    phase = "random";
    for (int i = 0; i < 400; i++) begin
      st = nop();
      st.rs1  = 5'($urandom_range(0, 3));
      st.rs2  = 5'($urandom_range(0, 3));
      st.u1   = 1'($urandom_range(0, 1));
      st.u2   = 1'($urandom_range(0, 1));
      st.rd   = 5'($urandom_range(0, 3));
      st.mrd  = 1'($urandom_range(0, 1));
      st.jt   = ($urandom_range(0, 5) == 0);
      st.ja   = $urandom;
      st.mq   = ($urandom_range(0, 3) == 0);
      st.mrdy = ($urandom_range(0, 2) == 0);
      st.rst_n = ($urandom_range(0, 99) != 0);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
